occupancy_grid_scanner: RTL

//  Read side of the double-buffered boid occupancy bitmap. On a start pulse it scans
//  the frozen buffer row-major through the bitmap read port (addr/data, 1-cycle latency).
//  It emits one beat per cell, with x/y and the occupied bit, on a valid/ready stream
//  for the renderer. Backpressure is absorbed by a 2-entry credit-limited skid buffer,
//  and the block counts occupied cells per frame.

---
 rtl/occupancy_grid_scanner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/occupancy_grid_scanner.sv
// Occupancy bitmap read-side scanner: row-major scan of the frozen buffer,
// streamed one cell per beat through a 2-entry credit-limited skid buffer.
module occupancy_grid_scanner #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic                  ram_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [X_WIDTH-1:0]    out_x,
    output logic [Y_WIDTH-1:0]    out_y,
    output logic                  out_occupied,
    output logic                  out_last,
    output logic [ADDR_WIDTH:0]   occ_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic               occ;
        logic               last;
    } beat_t;

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(GRID_W - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(GRID_H - 1);

    state_t                state_q, state_d;
    logic [X_WIDTH-1:0]    ix_q, ix_d;
    logic [Y_WIDTH-1:0]    iy_q, iy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  fl_q, fl_d;
    logic [X_WIDTH-1:0]    fx_q, fx_d;
    logic [Y_WIDTH-1:0]    fy_q, fy_d;
    logic                  flast_q, flast_d;
    beat_t                 e0_q, e0_d;
    beat_t                 e1_q, e1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    beat_t       head;
    logic        valid;
    logic        hs;
    logic        pop;
    logic        push;
    logic        issue;
    logic        start_ok;
    logic        last_cell;
    logic [2:0]  used;
    logic [1:0]  widx;
    beat_t       nb;

    // With the skid empty, the in-flight read is presented straight from the port.
    always_comb begin
        head = e0_q;
        if (cnt_q == 2'd0) begin
            head.x    = fx_q;
            head.y    = fy_q;
            head.occ  = fl_q & ram_read_data;
            head.last = fl_q & flast_q;
        end
    end

    assign valid     = (cnt_q != 2'd0) | fl_q;
    assign hs        = valid & out_ready;
    assign pop       = hs & (cnt_q != 2'd0);
    assign push      = fl_q & ~(hs & (cnt_q == 2'd0));
    assign used      = {1'b0, cnt_q} + {2'b0, fl_q} - {2'b0, hs};
    assign issue     = (state_q == SCAN) & (used < 3'd2);
    assign start_ok  = start & (state_q == IDLE) & ~done_q;
    assign last_cell = (ix_q == X_LAST) & (iy_q == Y_LAST);
    assign widx      = cnt_q - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        addr_d  = addr_q;
        raddr_d = raddr_q;
        fl_d    = issue;
        fx_d    = fx_q;
        fy_d    = fy_q;
        flast_d = flast_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q - {1'b0, pop} + {1'b0, push};
        occ_d   = occ_q;
        done_d  = hs & head.last;

        nb.x    = fx_q;
        nb.y    = fy_q;
        nb.occ  = ram_read_data;
        nb.last = flast_q;

        if (start_ok) begin
            state_d = SCAN;
            ix_d    = '0;
            iy_d    = '0;
            addr_d  = '0;
            occ_d   = '0;
        end

        if (issue) begin
            raddr_d = addr_q;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            fx_d    = ix_q;
            fy_d    = iy_q;
            flast_d = last_cell;
            if (ix_q == X_LAST) begin
                ix_d = '0;
                iy_d = iy_q + Y_WIDTH'(1);
            end else begin
                ix_d = ix_q + X_WIDTH'(1);
            end
            if (last_cell) state_d = DRAIN;
        end

        if (pop) e0_d = e1_q;
        if (push) begin
            if (widx == 2'd0) e0_d = nb;
            else              e1_d = nb;
        end

        if (hs && head.occ) occ_d = occ_q + (ADDR_WIDTH+1)'(1);
        if (hs && head.last) state_d = IDLE;

        busy_d = (state_d != IDLE) | done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ix_q    <= '0;
            iy_q    <= '0;
            addr_q  <= '0;
            raddr_q <= '0;
            fl_q    <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
            flast_q <= 1'b0;
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= 2'd0;
            occ_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            fl_q    <= fl_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            flast_q <= flast_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        ram_read_addr = '0;
        if (state_q != IDLE) ram_read_addr = issue ? addr_q : raddr_q;
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign out_valid    = valid;
    assign out_x        = head.x;
    assign out_y        = head.y;
    assign out_occupied = head.occ;
    assign out_last     = head.last;
    assign occ_count    = occ_q;

endmodule
